// File: rtl/result_pkg.sv
// Shared constants and types for the result writer: widths, FSM encoding and
// the four-result group record carried through the hold/skid slots.
package result_pkg;

  localparam int DATA_W  = 18;
  localparam int RAM_DW  = 32;
  localparam int ADDR_W  = 8;
  localparam int GROUP_N = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // data[0] is mu1 ... data[3] is mu4
  typedef struct packed {
    logic                             done;
    logic [GROUP_N-1:0][DATA_W-1:0]   data;
  } group_t;

endpackage

// File: rtl/result_writer_group_skid.sv
// Hold/skid group pair: hold is the group being drained, skid absorbs one
// group arriving mid-drain; a third group arriving mid-drain is dropped.
module group_skid
  import result_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic                           advance,
  input  group_t                         in_group,
  output logic                           hold_valid,
  output logic [GROUP_N-1:0][DATA_W-1:0] hold_data,
  output logic                           hold_done,
  output group_t                         hold_nxt,
  output logic                           skid_valid,
  output logic                           drop
);

  group_t hold_q, skid_q, skid_nxt;
  logic   hold_v_nxt, skid_v_nxt;

  // advance: the last word of hold is being written this cycle
  always_comb begin
    hold_v_nxt = hold_valid;
    hold_nxt   = hold_q;
    skid_v_nxt = skid_valid;
    skid_nxt   = skid_q;
    drop       = 1'b0;
    if (!hold_valid) begin
      if (load) begin
        hold_v_nxt = 1'b1;
        hold_nxt   = in_group;
      end
    end else if (advance) begin
      if (skid_valid) begin
        hold_nxt = skid_q;
        if (load) skid_nxt   = in_group;
        else      skid_v_nxt = 1'b0;
      end else if (load) begin
        hold_nxt = in_group;
      end else begin
        hold_v_nxt = 1'b0;
      end
    end else if (load) begin
      if (!skid_valid) begin
        skid_v_nxt = 1'b1;
        skid_nxt   = in_group;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      skid_valid <= 1'b0;
      hold_q     <= '0;
      skid_q     <= '0;
    end else begin
      hold_valid <= hold_v_nxt;
      skid_valid <= skid_v_nxt;
      hold_q     <= hold_nxt;
      skid_q     <= skid_nxt;
    end
  end

  assign hold_data = hold_q.data;
  assign hold_done = hold_q.done;

endmodule

// File: rtl/result_writer.sv
// Serialises four-result ALU groups into the result SRAM, one word per cycle
// at consecutive addresses, and flags matrix completion.
module result_writer
  import result_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mu1,
  input  logic [DATA_W-1:0] mu2,
  input  logic [DATA_W-1:0] mu3,
  input  logic [DATA_W-1:0] mu4,
  input  logic              web_in,
  input  logic              alu_done_in,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_wdata,
  output logic              busy,
  output logic              mat_done,
  output logic              overflow,
  output state_t            state_dbg
);

  state_t                         state, state_nxt;
  logic [1:0]                     k, k_nxt;
  logic [ADDR_W-1:0]              wptr;
  group_t                         in_group, hold_nxt;
  logic [GROUP_N-1:0][DATA_W-1:0] hold_data;
  logic                           hold_valid, hold_done, skid_valid, drop, advance;
  logic [DATA_W-1:0]              word_nxt;

  assign in_group.done = alu_done_in;
  assign in_group.data = {mu4, mu3, mu2, mu1};
  assign advance       = (state == WRITE) && (k == 2'd3);

  group_skid u_slots (
    .clk        (clk),
    .rst        (rst),
    .load       (web_in),
    .advance    (advance),
    .in_group   (in_group),
    .hold_valid (hold_valid),
    .hold_data  (hold_data),
    .hold_done  (hold_done),
    .hold_nxt   (hold_nxt),
    .skid_valid (skid_valid),
    .drop       (drop)
  );

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (web_in) begin
          state_nxt = WRITE;
          k_nxt     = 2'd0;
        end
      end
      WRITE: begin
        if (k == 2'd3) begin
          k_nxt     = 2'd0;
          state_nxt = (skid_valid || web_in) ? WRITE : IDLE;
        end else begin
          k_nxt = k + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A fresh group (k restarting at 0) is not in hold yet, so take it from hold_nxt.
  assign word_nxt = (k_nxt == 2'd0) ? hold_nxt.data[0] : hold_data[k_nxt];

  // Output registers are loaded with the word of the state being entered, so a
  // capture at cycle t drives its first SRAM write during cycle t+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 2'd0;
      wptr      <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      mat_done  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      ram_we   <= (state_nxt == WRITE);
      mat_done <= advance && hold_done;
      overflow <= overflow | drop;
      if (state_nxt == WRITE) begin
        ram_addr  <= wptr;
        ram_wdata <= {{(RAM_DW-DATA_W){1'b0}}, word_nxt};
        wptr      <= wptr + ADDR_W'(1);
      end
    end
  end

  assign busy      = hold_valid | skid_valid;
  assign state_dbg = state;

endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: per-scenario tasks over a word-queue reference
// model (a group is accepted only if at most four words remain queued).
module tb_result_writer;
  import result_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] mu1 = '0, mu2 = '0, mu3 = '0, mu4 = '0;
  logic              web_in = 1'b0;
  logic              alu_done_in = 1'b0;
  logic              ram_we, busy, mat_done, overflow;
  logic [ADDR_W-1:0] ram_addr;
  logic [RAM_DW-1:0] ram_wdata;
  state_t            state_dbg;

  result_writer dut (
    .clk(clk), .rst(rst), .mu1(mu1), .mu2(mu2), .mu3(mu3), .mu4(mu4),
    .web_in(web_in), .alu_done_in(alu_done_in), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy),
    .mat_done(mat_done), .overflow(overflow), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: each entry is {addr, data} of an expected SRAM write
  logic [ADDR_W+RAM_DW-1:0] exp_q[$];
  int                       md_q[$];
  logic [ADDR_W+RAM_DW-1:0] last_ad = '0;
  logic [ADDR_W-1:0]        waddr = '0;
  logic [ADDR_W-1:0]        prev_obs = '0;
  logic                     ovf_m = 1'b0;
  logic                     saw_wrap = 1'b0;
  int cyc = 0, total = 0, bad = 0, nwrites = 0, nmd = 0;

  function automatic logic [DATA_W-1:0] rnd18();
    return DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
  endfunction

  task automatic tick(input logic r, input logic w, input logic dn,
                      input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                      input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
    logic [DATA_W-1:0] d[4];
    int   pend;
    logic exp_we, exp_md;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    rst = r; web_in = w; alu_done_in = dn;
    mu1 = d0; mu2 = d1; mu3 = d2; mu4 = d3;
    @(posedge clk);
    cyc++;
    if (r) begin
      exp_q.delete(); md_q.delete();
      waddr = '0; ovf_m = 1'b0; last_ad = '0;
    end else if (w) begin
      pend = exp_q.size();
      if (pend <= 4) begin
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back({waddr, {(RAM_DW-DATA_W){1'b0}}, d[i]});
          waddr = waddr + 8'd1;
        end
        if (dn) md_q.push_back(cyc + pend + 4);
      end else begin
        ovf_m = 1'b1;
      end
    end
    #1;
    exp_we = (exp_q.size() > 0);
    if (exp_we) last_ad = exp_q.pop_front();
    exp_md = (md_q.size() > 0) && (md_q[0] == cyc);
    if (exp_md) void'(md_q.pop_front());
    total += 6;
    if (ram_we !== exp_we) begin bad++; $display("FAIL ram_we cyc=%0d got=%b exp=%b", cyc, ram_we, exp_we); end
    if (busy !== exp_we) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_we); end
    if (ram_addr !== last_ad[ADDR_W+RAM_DW-1:RAM_DW]) begin
      bad++; $display("FAIL ram_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, last_ad[ADDR_W+RAM_DW-1:RAM_DW]);
    end
    if (ram_wdata !== last_ad[RAM_DW-1:0]) begin
      bad++; $display("FAIL ram_wdata cyc=%0d got=%h exp=%h", cyc, ram_wdata, last_ad[RAM_DW-1:0]);
    end
    if (mat_done !== exp_md) begin bad++; $display("FAIL mat_done cyc=%0d got=%b exp=%b", cyc, mat_done, exp_md); end
    if (overflow !== ovf_m) begin bad++; $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, ovf_m); end
    if (ram_we === 1'b1) begin
      nwrites++;
      if (prev_obs == 8'hFF && ram_addr == 8'h00) saw_wrap = 1'b1;
      prev_obs = ram_addr;
    end
    if (mat_done === 1'b1) nmd++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic group(input logic dn);
    tick(1'b0, 1'b1, dn, rnd18(), rnd18(), rnd18(), rnd18());
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    tick(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    total += 2;
    if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
    if ({ram_we, busy, mat_done, overflow, ram_addr, ram_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs got we=%b busy=%b md=%b ovf=%b addr=%h data=%h exp all zero",
                      ram_we, busy, mat_done, overflow, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_single();
    int w0 = nwrites, m0 = nmd;
    tick(1'b0, 1'b1, 1'b0, 18'd1, 18'd2, 18'd3, 18'h3FFFF);
    total++;
    if (ram_addr !== 8'h00 || ram_wdata !== 32'h1) begin
      bad++; $display("FAIL single_first got addr=%h data=%h exp addr=00 data=1", ram_addr, ram_wdata);
    end
    idle(3);
    total++;
    if (ram_addr !== 8'h03 || ram_wdata !== 32'h0003FFFF) begin
      bad++; $display("FAIL single_last got addr=%h data=%h exp addr=03 data=0003ffff", ram_addr, ram_wdata);
    end
    idle(5);
    total++;
    if (nwrites - w0 !== 4 || nmd - m0 !== 0) begin
      bad++; $display("FAIL single_count got writes=%0d md=%0d exp writes=4 md=0", nwrites - w0, nmd - m0);
    end
  endtask

  task automatic test_matrix();
    int m0 = nmd;
    for (int g = 0; g < 4; g++) begin
      group(g == 3);
      idle(7);
    end
    idle(4);
    total++;
    if (nmd - m0 !== 1 || overflow !== 1'b0) begin
      bad++; $display("FAIL matrix got md=%0d ovf=%b exp md=1 ovf=0", nmd - m0, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = nwrites;
    group(1'b0);
    idle(1);
    group(1'b1);
    idle(10);
    total++;
    if (nwrites - w0 !== 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", nwrites - w0); end
  endtask

  task automatic test_overflow();
    int w0 = nwrites;
    group(1'b0);
    group(1'b0);
    group(1'b1);
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    idle(12);
    total += 2;
    if (nwrites - w0 !== 8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", nwrites - w0); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) group($urandom_range(0, 7) == 0);
      else idle(1);
    end
    idle(12);
  endtask

  task automatic test_wrap();
    saw_wrap = 1'b0;
    for (int g = 0; g < 65; g++) begin
      group(1'b0);
      idle(3);
    end
    idle(2);
    total++;
    if (saw_wrap !== 1'b1) begin bad++; $display("FAIL wrap got=%b exp=1", saw_wrap); end
  endtask

  task automatic test_reset_mid();
    idle(2);
    group(1'b1);
    idle(1);
    tick(1'b1, 1'b1, 1'b0, rnd18(), rnd18(), rnd18(), rnd18());
    total++;
    if ({ram_we, busy, ram_addr, ram_wdata} !== '0) begin
      bad++; $display("FAIL mid_reset got we=%b busy=%b addr=%h data=%h exp all zero",
                      ram_we, busy, ram_addr, ram_wdata);
    end
    idle(6);
    group(1'b0);
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h00) begin
      bad++; $display("FAIL mid_restart got we=%b addr=%h exp we=1 addr=00", ram_we, ram_addr);
    end
    idle(8);
  endtask

  initial begin
    test_reset();
    test_single();
    do_reset();
    test_matrix();
    do_reset();
    test_back_to_back();
    test_overflow();
    test_random();
    do_reset();
    test_wrap();
    test_reset_mid();
    idle(10);
    total++;
    if (exp_q.size() !== 0 || md_q.size() !== 0) begin
      bad++; $display("FAIL drained got words=%0d md=%0d exp 0 0", exp_q.size(), md_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_writer.md
# result_writer

Downstream of the mul-accumulate ALU stage. Captures the four 18-bit accumulator results (MU1..MU4) each time the ALU pulses its write-enable, then serialises them into a single-port result SRAM, one word per cycle, at consecutive addresses. A skid slot absorbs a second result group that arrives while the first is still draining. The block signals matrix completion once the final group flagged by ALU_done has been fully written.

## Interface
- `DATA_W`, 18: width of each ALU result.
- `RAM_DW`, 32: result SRAM word width; results are zero-extended into it.
- `ADDR_W`, 8: result SRAM address width.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `mu1`..`mu4`  in  DATA_W each: ALU results; valid in the cycle `web_in`=1.
- `web_in`  in  1: ALU group-valid pulse (one cycle).
- `alu_done_in`  in  1: the ALU marks this group as the last of the matrix; sampled only when `web_in`=1.
- `ram_we`  out  1: SRAM write strobe.
- `ram_addr`  out  ADDR_W: SRAM write address.
- `ram_wdata`  out  RAM_DW: `{(RAM_DW-DATA_W)'0, result}`.
- `busy`  out  1: high while either the hold slot or the skid slot is occupied.
- `mat_done`  out  1: one-cycle pulse after the last write of a done-flagged group.
- `overflow`  out  1: sticky; set when a group is dropped. Cleared only by `rst`.

## Operation
- Two group slots, hold and skid. Each slot stores 4×DATA_W data plus a done bit.
- FSM states:
  - IDLE: hold is empty.
  - WRITE: draining hold; a 2-bit index `k` selects the word, 0→3 = mu1→mu4.
- Capture rule when `web_in`=1:
  - IDLE: capture into hold; go to WRITE with `k`=0.
  - WRITE with `k`<3 and skid empty: capture into skid.
  - WRITE with `k`=3: hold is freeing this cycle. If skid is full, skid moves to hold and the new group goes into skid. Otherwise the new group goes straight into hold. Either way the next cycle is WRITE with `k`=0.
  - WRITE with `k`<3 and skid full: drop the group and set `overflow`. Hold and skid are unaffected.
- WRITE, every cycle:
  - Drive `ram_we`=1, `ram_addr`=`wptr`, `ram_wdata`=hold word `k`.
  - Then `wptr`←`wptr`+1 (wraps modulo 2^ADDR_W) and `k`←`k`+1.
- End of drain (`k`=3):
  - If the hold done bit is set, pulse `mat_done` in the next cycle.
  - Then load hold from skid if skid is full (or from `web_in` as above) and stay in WRITE. Otherwise go to IDLE.
- `wptr` is never reset by `mat_done`; matrices pack contiguously, 16 words each.
- A `web_in` with `alu_done_in`=1 that is dropped still sets `overflow`, and `mat_done` is not produced for it.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `busy`=0, `mat_done`=0, `overflow`=0. Internally: FSM=IDLE, `wptr`=0, `k`=0, both slots empty.
- `rst` mid-drain discards both slots; the next cycle is IDLE.
- Write latency: `web_in` at cycle t gives writes at t+1..t+4, addresses `wptr`..`wptr`+3.
- Outputs are registered. `ram_addr` and `ram_wdata` hold their last values while `ram_we`=0.
- `mat_done` is asserted at t+5 for a done-flagged group captured directly into an idle hold.
- Sustained throughput: one group per 4 cycles with no loss. The ALU delivers one group per 8 cycles, so the skid is margin.
- `web_in` in the same cycle as `rst` is ignored.

## Structure
- Shared package `result_pkg`:
  - Constants `DATA_W`, `RAM_DW`, `ADDR_W`, and `GROUP_N`=4.
  - FSM state encoding `{IDLE, WRITE}`.
  - Group record type: 4×DATA_W data plus a done bit.
- One natural sub-module, `group_skid`: the hold/skid pair with load/advance/drop control, exposing `hold_valid`, `hold_data`, `hold_done` and `drop`.
- The top level holds the FSM, `k`, `wptr`, and the output registers.

## Test plan
- Reset, then one `web_in` with mu1..4 = 1, 2, 3, 0x3FFFF. Expect writes at cycles t+1..t+4 to addresses 0..3 with data 0x1, 0x2, 0x3, 0x0003FFFF; `busy` high for 4 cycles; no `mat_done`.
- Four groups at 8-cycle spacing, the last with `alu_done_in`=1. Expect addresses 0..15 in order, a single `mat_done` pulse the cycle after the address-15 write, and `overflow`=0.
- Second `web_in` 2 cycles after the first. Expect it held in skid; 8 back-to-back writes at addresses 0..7; no gap cycle with `ram_we`=0.
- Three `web_in` on consecutive cycles. Expect the third dropped, `overflow`=1 and sticky, and only 8 words written.
- With `wptr`=0xFE, write one group. Expect addresses 0xFE, 0xFF, 0x00, 0x01.
- Assert `rst` during the second write of a group. Expect no further `ram_we`, all outputs at reset values, and the next group written starting at address 0.
